inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Writer side of the instruction memory. It receives a byte stream from a host link (UART or debug bridge front-end), assembles little-endian 32-bit instructions and writes them sequentially from address 0 into the RAM-backed instruction memory.
- Holds the core in reset while loading and verifies a trailing additive checksum before releasing it.
- Sits between the host byte interface and the instruction memory write port. The core's fetch path stays on the read port.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; depth = 2**ADDR_WIDTH words.
- INST_WIDTH, 32, instruction width. The block supports 32 only, which is 4 bytes per word.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, synchronous active-low reset.
- i_start, input, 1, single-cycle pulse that begins a load session. Ignored unless in IDLE, DONE or ERR.
- i_num_words, input, ADDR_WIDTH+1, number of instruction words to load. Sampled on i_start.
- i_byte, input, 8, incoming byte.
- i_byte_valid, input, 1, i_byte is valid this cycle.
- o_byte_ready, output, 1, loader accepts a byte this cycle.
- o_we, output, 1, instruction memory write enable.
- o_waddr, output, ADDR_WIDTH, word write address.
- o_wdata, output, INST_WIDTH, write data.
- o_core_rst_n, output, 1, active-low reset to the core.
- o_busy, output, 1, a session is in progress.
- o_done, output, 1, the last session completed with a good checksum.
- o_err, output, 1, the last session failed.

Behaviour:
- Reset: synchronous on i_clk when i_rst_n = 0. State goes to IDLE. Output reset values:
  - o_byte_ready = 0, o_we = 0, o_waddr = 0, o_wdata = 0
  - o_core_rst_n = 0, o_busy = 0, o_done = 0, o_err = 0
  - Byte counter, word counter and checksum accumulator clear to 0.
- Byte handshake: a byte transfers only when o_byte_ready && i_byte_valid are high on the same cycle.
  - o_byte_ready = 1 exactly in the RECV and CHK states.
  - The block never back-pressures mid-word.
- FSM states: IDLE, RECV, CHK, DONE, ERR.
- IDLE / DONE / ERR on i_start:
  - If i_num_words == 0 or i_num_words > 2**ADDR_WIDTH, go to ERR next cycle: o_err = 1, o_done = 0.
  - Otherwise go to RECV. Latch the word count, clear the counters and checksum, set o_done = o_err = 0, o_busy = 1, o_core_rst_n = 0.
- RECV:
  - Byte k of a word (k = 0..3) fills bits [8k+7:8k]; byte 0 is the LSB.
  - On acceptance of byte 3, on the next cycle: o_we = 1 for exactly one cycle, o_waddr = word index, o_wdata = the assembled word.
  - Checksum accumulator += word, modulo 2**32.
  - After the latched word count has been written, go to CHK. The word index starts at 0, increments after each write, and never wraps within a valid session.
- CHK:
  - Assemble 4 more bytes, little-endian, into the expected checksum. No memory write occurs.
  - On byte 3 acceptance, compare against the accumulator, which includes the final word.
  - Match: go to DONE (o_done = 1, o_busy = 0, o_core_rst_n = 1).
  - Mismatch: go to ERR (o_err = 1, o_busy = 0, o_core_rst_n stays 0).
- DONE: o_core_rst_n = 1 is held until the next accepted i_start or reset.
- ERR: core held in reset. Only i_start or i_rst_n leaves ERR.
- o_we and o_byte_ready are never high in IDLE, DONE or ERR.
- i_start during RECV or CHK is ignored; it does not restart the session.
- i_byte_valid outside RECV/CHK is ignored; no state changes.
- Reset mid-session aborts the load. Words already written stay in memory. Outputs take their reset values, and the core stays in reset until the next good session.
- The write of word N-1 and the first CHK byte may coincide; both complete.
- Full-depth load (i_num_words = 2**ADDR_WIDTH): the last write goes to address 2**ADDR_WIDTH-1 and there is no wrap to 0.

Decomposition:
- Shared package (riscv_pkg), which gains:
  - the loader state enum (IDLE, RECV, CHK, DONE, ERR);
  - BYTES_PER_INST = 4;
  - CHECKSUM_WIDTH = 32.
- One natural sub-module: byte_packer. It is a shift/assembly register with a 2-bit byte index, taking byte + strobe and emitting a word + word_valid. It is instantiated once and reused by RECV and CHK; the FSM selects which consumer latches its output.

Test Plan:
1. Basic load: i_num_words = 2, bytes 13 00 00 00 93 00 10 00, checksum bytes A6 00 10 00 -> writes addr 0 = 0x00000013 and addr 1 = 0x00100093, each o_we one cycle. Then o_done = 1, o_core_rst_n = 1, o_err = 0.
2. Bad checksum: same words, checksum bytes 00 00 00 00 -> both writes occur, then o_err = 1, o_done = 0, o_core_rst_n = 0.
3. Illegal count: i_num_words = 0, then i_num_words = 257 (ADDR_WIDTH = 8) -> ERR next cycle each time. o_byte_ready never goes high and o_we never goes high.
4. Gapped stream: the test-1 stream with i_byte_valid deasserted for random 0-5 cycles between bytes, and i_start pulsed mid-session -> results identical to test 1; the session does not restart.
5. Reset mid-load: i_num_words = 4, assert i_rst_n = 0 after 6 bytes -> all outputs at reset values next cycle. A following good 1-word session (0xDEADBEEF, checksum EF BE AD DE) ends in DONE with addr 0 = 0xDEADBEEF.
6. Full depth: i_num_words = 256 with word i = i -> last write to addr 255 with data 255. Correct checksum 0x00007F80 -> DONE. No write to addr 0 after the first.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and byte/word geometry.
package riscv_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_CHK,
    LD_DONE,
    LD_ERR
  } loader_state_e;

  localparam int BYTE_BITS      = 8;
  localparam int BYTES_PER_INST = 4;
  localparam int INST_BITS      = BYTES_PER_INST * BYTE_BITS;
  localparam int CHECKSUM_WIDTH = 32;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler. The word is presented combinationally on the
// strobe of the last byte so the consumer can latch it on that same edge.
module byte_packer
  import riscv_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic [BYTE_BITS-1:0] i_byte,
  input  logic                 i_byte_stb,
  output logic [INST_BITS-1:0] o_word,
  output logic                 o_word_valid
);

  localparam int IDX_W = $clog2(BYTES_PER_INST);
  localparam int LOW_W = INST_BITS - BYTE_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_INST - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LOW_W-1:0] low_q, low_d;

  // Bytes enter at the top and shift down, so after three bytes byte 0 sits at bit 0.
  always_comb begin
    idx_d = idx_q;
    low_d = low_q;
    if (i_clr) begin
      idx_d = '0;
      low_d = '0;
    end else if (i_byte_stb) begin
      idx_d = idx_q + IDX_W'(1);
      low_d = {i_byte, low_q[LOW_W-1:BYTE_BITS]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx_q <= '0;
      low_q <= '0;
    end else begin
      idx_q <= idx_d;
      low_q <= low_d;
    end
  end

  assign o_word       = {i_byte, low_q};
  assign o_word_valid = i_byte_stb && (idx_q == LAST_IDX);

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte stream into instruction memory, checks the trailing additive checksum,
// and releases the core from reset only after a clean load.
//   state | meaning
//   IDLE  | no session since reset, core held in reset
//   RECV  | receiving instruction words and writing them to memory
//   CHK   | receiving the 4-byte checksum
//   DONE  | good load, core released
//   ERR   | bad count or checksum, core held in reset
module inst_mem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [INST_WIDTH-1:0] o_wdata,
  output logic                  o_core_rst_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  loader_state_e             state_q;
  logic [CNT_W-1:0]          num_words_q;
  logic [CNT_W-1:0]          word_cnt_q;
  logic [CHECKSUM_WIDTH-1:0] acc_q;

  logic                      byte_ready_q;
  logic                      we_q;
  logic [ADDR_WIDTH-1:0]     waddr_q;
  logic [INST_WIDTH-1:0]     wdata_q;
  logic                      core_rst_n_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;

  logic                      byte_stb;
  logic                      idle_like;
  logic                      start_ok;
  logic                      count_ok;
  logic [INST_BITS-1:0]      pk_word;
  logic                      pk_valid;

  assign byte_stb  = byte_ready_q && i_byte_valid;
  assign idle_like = (state_q == LD_IDLE) || (state_q == LD_DONE) || (state_q == LD_ERR);
  assign start_ok  = i_start && idle_like;
  assign count_ok  = (i_num_words != '0) && (i_num_words <= DEPTH);

  byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (start_ok),
    .i_byte       (i_byte),
    .i_byte_stb   (byte_stb),
    .o_word       (pk_word),
    .o_word_valid (pk_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= LD_IDLE;
      num_words_q  <= '0;
      word_cnt_q   <= '0;
      acc_q        <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (i_start) begin
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
            if (count_ok) begin
              state_q      <= LD_RECV;
              num_words_q  <= i_num_words;
              word_cnt_q   <= '0;
              acc_q        <= '0;
              err_q        <= 1'b0;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
            end else begin
              state_q <= LD_ERR;
              err_q   <= 1'b1;
            end
          end
        end

        // Ready stays high into CHK so the first checksum byte can overlap the last write.
        LD_RECV: begin
          if (pk_valid) begin
            we_q       <= 1'b1;
            waddr_q    <= word_cnt_q[ADDR_WIDTH-1:0];
            wdata_q    <= pk_word;
            acc_q      <= acc_q + pk_word;
            word_cnt_q <= word_cnt_q + CNT_ONE;
            if (word_cnt_q == num_words_q - CNT_ONE) begin
              state_q <= LD_CHK;
            end
          end
        end

        LD_CHK: begin
          if (pk_valid) begin
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            if (pk_word == acc_q) begin
              state_q      <= LD_DONE;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q <= LD_ERR;
              err_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q      <= LD_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_ready = byte_ready_q;
  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: session scenarios checked against a word-list / checksum model.
module tb_inst_mem_loader;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic [7:0]    byte_in;
  logic          bvalid;
  logic          o_byte_ready;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [IW-1:0] o_wdata;
  logic          o_core_rst_n;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] waddr_log[$];
  logic [31:0]   wdata_log[$];
  logic [31:0]   sess_words[$];
  int            we_hi_cnt = 0;
  int            rdy_hi_cnt = 0;
  int            we_double = 0;
  logic          prev_we = 1'b0;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_num_words  (num_words),
    .i_byte       (byte_in),
    .i_byte_valid (bvalid),
    .o_byte_ready (o_byte_ready),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_core_rst_n (o_core_rst_n),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always @(negedge clk) begin
    if (o_we) begin
      waddr_log.push_back(o_waddr);
      wdata_log.push_back(o_wdata);
      we_hi_cnt++;
    end
    if (o_we && prev_we) we_double++;
    prev_we = o_we;
    if (o_byte_ready) rdy_hi_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // Reference: plain sum of the session words, wrapping at 32 bits.
  function automatic logic [31:0] model_sum();
    logic [31:0] s = 32'h0;
    foreach (sess_words[i]) s = s + sess_words[i];
    return s;
  endfunction

  task automatic pulse_start(input logic [AW:0] n);
    num_words = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   g;
    logic acc;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) @(negedge clk);
    byte_in = b;
    bvalid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50; c++) begin
      acc = o_byte_ready;
      @(negedge clk);
      if (acc) break;
    end
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept timeout: ready=%b required=1", acc);
    end
    bvalid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({o_byte_ready, o_we, o_waddr, o_wdata, o_core_rst_n, o_busy, o_done, o_err} !== '0) begin
      errors++;
      $display("FAIL %s reset_vals: rdy=%b we=%b waddr=%h wdata=%h core_rst_n=%b busy=%b done=%b err=%b required all 0",
               tag, o_byte_ready, o_we, o_waddr, o_wdata, o_core_rst_n, o_busy, o_done, o_err);
    end
  endtask

  // Runs a full session from sess_words; mid_start_at pulses a stray i_start before that byte index.
  task automatic run_session(input string tag, input logic [31:0] csum, input int max_gap,
                             input int mid_start_at);
    logic [31:0] w;
    logic        exp_ok;
    int          n;
    waddr_log.delete();
    wdata_log.delete();
    we_double = 0;
    pulse_start((AW+1)'(sess_words.size()));
    checks++;
    if ({o_busy, o_core_rst_n, o_done, o_err, o_byte_ready} !== 5'b10001) begin
      errors++;
      $display("FAIL %s start_flags: busy/core/done/err/rdy=%b%b%b%b%b required 10001",
               tag, o_busy, o_core_rst_n, o_done, o_err, o_byte_ready);
    end
    n = 0;
    foreach (sess_words[i]) begin
      w = sess_words[i];
      for (int k = 0; k < 4; k++) begin
        if (n == mid_start_at) pulse_start((AW+1)'(1));
        send_byte(w[8*k +: 8], max_gap);
        n++;
      end
    end
    for (int k = 0; k < 4; k++) send_byte(csum[8*k +: 8], max_gap);
    @(negedge clk);
    @(negedge clk);
    exp_ok = (csum == model_sum());
    checks++;
    if ({o_done, o_err, o_core_rst_n, o_busy, o_byte_ready} !== {exp_ok, !exp_ok, exp_ok, 2'b00}) begin
      errors++;
      $display("FAIL %s outcome: done=%b err=%b core_rst_n=%b busy=%b rdy=%b required done=%b err=%b core_rst_n=%b busy=0 rdy=0",
               tag, o_done, o_err, o_core_rst_n, o_busy, o_byte_ready, exp_ok, !exp_ok, exp_ok);
    end
    checks++;
    if (waddr_log.size() != sess_words.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", tag, waddr_log.size(), sess_words.size());
    end
    checks++;
    if (we_double != 0) begin
      errors++;
      $display("FAIL %s we_pulse_width: %0d multi-cycle pulses required 0", tag, we_double);
    end
    foreach (sess_words[i]) begin
      if (i < waddr_log.size()) begin
        checks++;
        if (waddr_log[i] !== AW'(i) || wdata_log[i] !== sess_words[i]) begin
          errors++;
          $display("FAIL %s write[%0d]: got addr=%h data=%h required addr=%h data=%h",
                   tag, i, waddr_log[i], wdata_log[i], AW'(i), sess_words[i]);
        end
      end
    end
  endtask

  task automatic load_basic_words();
    sess_words.delete();
    sess_words.push_back(32'h0000_0013);
    sess_words.push_back(32'h0010_0093);
  endtask

  task automatic test_reset();
    check_reset_vals("reset");
  endtask

  task automatic test_basic();
    load_basic_words();
    run_session("basic", 32'h0010_00A6, 0, -1);
  endtask

  task automatic test_bad_checksum();
    load_basic_words();
    run_session("bad_csum", 32'h0, 0, -1);
  endtask

  task automatic test_illegal_count(input logic [AW:0] n);
    int r0, w0;
    r0 = rdy_hi_cnt;
    w0 = we_hi_cnt;
    pulse_start(n);
    checks++;
    if ({o_err, o_done, o_busy, o_core_rst_n} !== 4'b1000) begin
      errors++;
      $display("FAIL illegal_%0d flags: err/done/busy/core=%b%b%b%b required 1000",
               n, o_err, o_done, o_busy, o_core_rst_n);
    end
    byte_in = 8'h5A;
    bvalid = 1'b1;
    repeat (5) @(negedge clk);
    bvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_hi_cnt != r0 || we_hi_cnt != w0 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_%0d quiet: ready cycles=%0d we cycles=%0d err=%b required 0 0 1",
               n, rdy_hi_cnt - r0, we_hi_cnt - w0, o_err);
    end
  endtask

  task automatic test_gapped();
    load_basic_words();
    run_session("gapped", 32'h0010_00A6, 5, 3);
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w0;
    w0 = $urandom;
    waddr_log.delete();
    wdata_log.delete();
    pulse_start((AW+1)'(4));
    for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    checks++;
    if (wdata_log.size() != 1 || (wdata_log.size() == 1 && wdata_log[0] !== w0)) begin
      errors++;
      $display("FAIL mid_reset first_word: writes=%0d required 1 with data %h", wdata_log.size(), w0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    sess_words.delete();
    sess_words.push_back(32'hDEAD_BEEF);
    run_session("after_reset", 32'hDEAD_BEEF, 0, -1);
  endtask

  task automatic test_full_depth();
    sess_words.delete();
    for (int i = 0; i < 256; i++) sess_words.push_back(32'(i));
    run_session("full_depth", 32'h0000_7F80, 0, -1);
  endtask

  task automatic test_random();
    int          n;
    logic [31:0] cs;
    for (int s = 0; s < 4; s++) begin
      n = int'($urandom_range(12, 1));
      sess_words.delete();
      for (int i = 0; i < n; i++) sess_words.push_back($urandom);
      cs = model_sum();
      if (s % 2 == 1) cs = cs + 32'($urandom_range(255, 1));
      run_session("random", cs, 3, -1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_words = '0;
    byte_in = 8'h00;
    bvalid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_illegal_count((AW+1)'(0));
    test_basic();
    test_illegal_count((AW+1)'(257));
    test_bad_checksum();
    test_gapped();
    test_reset_mid_load();
    test_full_depth();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
